conv_layer_sequencer: RTL

Layer-level controller for the convolution accelerator. Given one layer descriptor, it splits the layer's kernels into weight passes. For each pass it requests a weight load, programs the accelerator's two AXI-Lite configuration registers over an AXI-Lite master write port, pulses `conv_en`, and waits for `w_done`. It sits between the host/DMA control logic and the accelerator's `s_axi_*` slave, `conv_en` and `w_done` pins.

---
 rtl/conv_layer_sequencer.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/conv_layer_sequencer.sv
// Layer-level sequencer for the convolution accelerator: splits a layer into weight passes,
// programs the accelerator over an AXI-Lite master write port, and kicks/awaits each pass.
module conv_layer_sequencer #(
  parameter logic [7:0] SHIFT_DEFAULT = 8'd8,
  parameter logic [3:0] REG0_ADDR     = 4'h0,
  parameter logic [3:0] REG1_ADDR     = 4'h4
) (
  input  logic        s_axi_aclk,
  input  logic        s_axi_aresetn,
  input  logic        start,
  input  logic [7:0]  cfg_tensor_size,
  input  logic [7:0]  cfg_kernel_size,
  input  logic [7:0]  cfg_stride,
  input  logic [7:0]  cfg_channels,
  input  logic [7:0]  cfg_shift,
  input  logic [9:0]  cfg_kernel_total,
  input  logic [9:0]  cfg_kernel_per_pass,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [9:0]  pass_idx,
  output logic        wt_req,
  output logic [9:0]  wt_kernels,
  input  logic        wt_done,
  output logic [3:0]  m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic        conv_en,
  input  logic        w_done
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WLOAD = 3'd1;
  localparam logic [2:0] ST_WR0   = 3'd2;
  localparam logic [2:0] ST_WR1   = 3'd3;
  localparam logic [2:0] ST_KICK  = 3'd4;
  localparam logic [2:0] ST_WAIT  = 3'd5;
  localparam logic [2:0] ST_NEXT  = 3'd6;

  function automatic logic [9:0] min10(input logic [9:0] a, input logic [9:0] b);
    if (a < b) begin
      min10 = a;
    end else begin
      min10 = b;
    end
  endfunction

  logic [2:0]  state_r;
  logic [7:0]  tensor_r, kernel_r, stride_r, channels_r, shift_r;
  logic [9:0]  per_pass_r, remaining_r, n_r, pass_idx_r, wt_kernels_r;
  logic        busy_r, done_r, err_r, wt_req_r, conv_en_r;
  logic        awvalid_r, wvalid_r, bready_r, aw_hs_r, w_hs_r;
  logic [3:0]  awaddr_r, wstrb_r;
  logic [31:0] wdata_r;

  logic [9:0]  per_pass_cfg_s, n_start_s, rem_next_s, n_next_s;
  logic [7:0]  shift_cfg_s;
  logic [31:0] wdata0_s, wdata1_s;
  logic        aw_ok_s, w_ok_s, last_pass_s;

  // Pass sizing, register images and handshake bookkeeping.
  always_comb begin
    per_pass_cfg_s = cfg_kernel_per_pass;
    if (cfg_kernel_per_pass == 10'd0) begin
      per_pass_cfg_s = cfg_kernel_total;
    end else begin
      per_pass_cfg_s = cfg_kernel_per_pass;
    end
    shift_cfg_s = cfg_shift;
    if (cfg_shift == 8'd0) begin
      shift_cfg_s = SHIFT_DEFAULT;
    end else begin
      shift_cfg_s = cfg_shift;
    end
    n_start_s   = min10(per_pass_cfg_s, cfg_kernel_total);
    rem_next_s  = remaining_r - n_r;
    n_next_s    = min10(per_pass_r, rem_next_s);
    last_pass_s = (remaining_r == n_r);
    aw_ok_s     = aw_hs_r | (awvalid_r & m_axi_awready);
    w_ok_s      = w_hs_r | (wvalid_r & m_axi_wready);
    wdata0_s    = {2'b00, tensor_r, 6'b000000, kernel_r, stride_r};
    wdata1_s    = {2'b00, channels_r, n_r, 3'b000, 1'b1, shift_r};
  end

  // Layer FSM, AXI-Lite write engine and all registered outputs.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_r      <= ST_IDLE;
      tensor_r     <= 8'd0;
      kernel_r     <= 8'd0;
      stride_r     <= 8'd0;
      channels_r   <= 8'd0;
      shift_r      <= 8'd0;
      per_pass_r   <= 10'd0;
      remaining_r  <= 10'd0;
      n_r          <= 10'd0;
      pass_idx_r   <= 10'd0;
      wt_kernels_r <= 10'd0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      wt_req_r     <= 1'b0;
      conv_en_r    <= 1'b0;
      awvalid_r    <= 1'b0;
      wvalid_r     <= 1'b0;
      bready_r     <= 1'b0;
      aw_hs_r      <= 1'b0;
      w_hs_r       <= 1'b0;
      awaddr_r     <= 4'h0;
      wstrb_r      <= 4'h0;
      wdata_r      <= 32'h0000_0000;
    end else begin
      done_r    <= 1'b0;
      conv_en_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            tensor_r    <= cfg_tensor_size;
            kernel_r    <= cfg_kernel_size;
            stride_r    <= cfg_stride;
            channels_r  <= cfg_channels;
            shift_r     <= shift_cfg_s;
            per_pass_r  <= per_pass_cfg_s;
            remaining_r <= cfg_kernel_total;
            n_r         <= n_start_s;
            pass_idx_r  <= 10'd0;
            err_r       <= 1'b0;
            if (cfg_kernel_total == 10'd0) begin
              done_r <= 1'b1;
            end else begin
              busy_r       <= 1'b1;
              wt_req_r     <= 1'b1;
              wt_kernels_r <= n_start_s;
              state_r      <= ST_WLOAD;
            end
          end
        end
        ST_WLOAD: begin
          if (wt_done) begin
            wt_req_r  <= 1'b0;
            awvalid_r <= 1'b1;
            wvalid_r  <= 1'b1;
            aw_hs_r   <= 1'b0;
            w_hs_r    <= 1'b0;
            awaddr_r  <= REG0_ADDR;
            wdata_r   <= wdata0_s;
            wstrb_r   <= 4'hF;
            state_r   <= ST_WR0;
          end
        end
        ST_WR0, ST_WR1: begin
          if (awvalid_r && m_axi_awready) begin
            awvalid_r <= 1'b0;
          end
          if (wvalid_r && m_axi_wready) begin
            wvalid_r <= 1'b0;
          end
          aw_hs_r <= aw_ok_s;
          w_hs_r  <= w_ok_s;
          if (!bready_r) begin
            if (aw_ok_s && w_ok_s) begin
              bready_r <= 1'b1;
            end
          end else if (m_axi_bvalid) begin
            bready_r <= 1'b0;
            if (m_axi_bresp != 2'b00) begin
              err_r   <= 1'b1;
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end else if (state_r == ST_WR0) begin
              awvalid_r <= 1'b1;
              wvalid_r  <= 1'b1;
              aw_hs_r   <= 1'b0;
              w_hs_r    <= 1'b0;
              awaddr_r  <= REG1_ADDR;
              wdata_r   <= wdata1_s;
              state_r   <= ST_WR1;
            end else begin
              conv_en_r <= 1'b1;
              state_r   <= ST_KICK;
            end
          end
        end
        ST_KICK: begin
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          // The final pass folds NEXT's bookkeeping in so done follows w_done by one cycle.
          if (w_done) begin
            if (last_pass_s) begin
              remaining_r <= rem_next_s;
              pass_idx_r  <= pass_idx_r + 10'd1;
              done_r      <= 1'b1;
              busy_r      <= 1'b0;
              state_r     <= ST_IDLE;
            end else begin
              state_r <= ST_NEXT;
            end
          end
        end
        ST_NEXT: begin
          remaining_r <= rem_next_s;
          pass_idx_r  <= pass_idx_r + 10'd1;
          if (rem_next_s == 10'd0) begin
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            n_r          <= n_next_s;
            wt_kernels_r <= n_next_s;
            wt_req_r     <= 1'b1;
            state_r      <= ST_WLOAD;
          end
        end
        default: begin
          busy_r    <= 1'b0;
          wt_req_r  <= 1'b0;
          awvalid_r <= 1'b0;
          wvalid_r  <= 1'b0;
          bready_r  <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy          = busy_r;
  assign done          = done_r;
  assign err           = err_r;
  assign pass_idx      = pass_idx_r;
  assign wt_req        = wt_req_r;
  assign wt_kernels    = wt_kernels_r;
  assign m_axi_awaddr  = awaddr_r;
  assign m_axi_awvalid = awvalid_r;
  assign m_axi_wdata   = wdata_r;
  assign m_axi_wstrb   = wstrb_r;
  assign m_axi_wvalid  = wvalid_r;
  assign m_axi_bready  = bready_r;
  assign conv_en       = conv_en_r;

endmodule
